logic_op_arbiter: RTL and testbench
===================================

# logic_op_arbiter

Shares one WIDTH-bit combinational gate unit (NOT/AND/OR/NOR/NAND/XOR/XNOR) between NUM_REQ requesters. Arbitration is round-robin. Each requester uses a valid/ready handshake. The operation is sequenced through a three-state FSM. One result is returned at a time on a single response channel tagged with the requester ID. The block sits between the bitwise-logic datapath and the clients that need gate evaluations.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- WIDTH, 8: operand/result width in bits

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_in  input  NUM_REQ  per-requester request valid
- req_op_in  input  3*NUM_REQ  per-requester opcode; slice i = bits [3i+2:3i]
- req_a_in  input  WIDTH*NUM_REQ  per-requester operand A, sliced likewise
- req_b_in  input  WIDTH*NUM_REQ  per-requester operand B
- req_ready_out  output  NUM_REQ  one-hot accept strobe
- rsp_valid_out  output  1  response valid
- rsp_ready_in  input  1  response consumer ready
- rsp_id_out  output  $clog2(NUM_REQ)  index of the served requester
- rsp_data_out  output  WIDTH  gate result

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- Opcodes: 0 NOT_A, 1 NOT_B, 2 AND, 3 OR, 4 NOR, 5 NAND, 6 XOR, 7 XNOR. All codes are legal.
- FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - Search req_valid_in starting at round-robin pointer ptr and wrap modulo NUM_REQ.
  - The first valid index found is the winner. req_ready_out[winner]=1 combinationally in this cycle; all other bits are 0.
  - At the clock edge, latch op, a, b and winner ID, set ptr ← (winner+1) mod NUM_REQ, and move to EXEC.
  - If no requester is valid, stay in IDLE and hold ptr.
- **EXEC:** register the gate unit output into rsp_data_out and move to RESP. req_ready_out is all zeros.
- **RESP:** rsp_valid_out=1. rsp_id_out and rsp_data_out stay stable. When rsp_valid_out && rsp_ready_in at an edge, move to IDLE. req_ready_out is all zeros.
- Request inputs are sampled only at the accept edge. Changes after that edge do not affect the in-flight operation.
- Requesters must hold valid, op and operands until accepted.
- Reset values: state=IDLE, ptr=0, rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, req_ready_out=0.
- Reset asserted in any state takes effect immediately. The in-flight transaction is dropped and no response follows release.

## Timing
- Accept at edge T. rsp_valid_out rises after edge T+1 (EXEC→RESP). Minimum latency from accept to response is 2 cycles.
- With rsp_ready_in held high, the response completes at edge T+2. The next accept can occur at edge T+3, giving a peak throughput of 1 operation per 3 cycles.
- req_ready_out depends combinationally on req_valid_in and the state. There is no combinational path from rsp_ready_in to req_ready_out.
- Backpressure: RESP holds indefinitely while rsp_ready_in=0. No new accept occurs.
- The pointer updates only on accept, which guarantees each continuously-valid requester is served within NUM_REQ grants.

## Configuration
- LOGIC_OP_ARB_CNT_EN defined:
  - Adds output port done_cnt_out [15:0], counting completed responses (handshakes in RESP).
  - Reset value is 0. The counter saturates at 16'hFFFF.
- LOGIC_OP_ARB_CNT_EN undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Package logic_op_pkg holds:
  - op_e enum with the 3-bit opcodes above
  - state_e enum {IDLE, EXEC, RESP}
  - localparam OP_W=3
- Sub-module logic_op_unit is purely combinational (op, a, b → y, WIDTH-parameterised) and is instantiated once.

## Test plan
Bench uses NUM_REQ=4, WIDTH=8.
- **Reset:** rst=1 with random inputs → req_ready_out=0, rsp_valid_out=0, rsp_data_out=8'h00, rsp_id_out=0.
- **Single request:** req1 AND with a=8'hF0, b=8'h3C → req_ready_out=4'b0010 in the accept cycle; 2 cycles later rsp_valid_out=1, rsp_id_out=1, rsp_data_out=8'h30.
- **Fairness:** all four requesters valid continuously, rsp_ready_in=1 → grant order 0,1,2,3,0,1, each 3 cycles apart.
- **Op coverage:** a=8'hCA, b=8'h53 on ops 0..7 → results 35, AC, 42, DB, 24, BD, 99, 66 (hex).
- **Backpressure:** rsp_ready_in=0 for 5 cycles in RESP → rsp_valid_out, ID and data held stable, req_ready_out=0, no accept; release gives one handshake then return to IDLE.
- **Reset mid-operation:** rst pulsed during EXEC → rsp_valid_out=0 immediately, no response after release, ptr=0, and done_cnt_out=0 when LOGIC_OP_ARB_CNT_EN is defined.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op arbiter: opcode and FSM state encodings.
package logic_op_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT_A = 3'd0,
        OP_NOT_B = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_NOR   = 3'd4,
        OP_NAND  = 3'd5,
        OP_XOR   = 3'd6,
        OP_XNOR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit gate unit: y = op(a, b).
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT_A: y = ~a;
            OP_NOT_B: y = ~b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between NUM_REQ requesters.
// Optional completed-response counter enabled by LOGIC_OP_ARB_CNT_EN.
//
// state | meaning
// IDLE  | search requests from ptr, accept the first valid one
// EXEC  | register gate unit result
// RESP  | hold response until rsp_ready_in
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [OP_W*NUM_REQ-1:0]  req_op_in,
    input  logic [WIDTH*NUM_REQ-1:0] req_a_in,
    input  logic [WIDTH*NUM_REQ-1:0] req_b_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [ID_W-1:0]          rsp_id_out,
    output logic [WIDTH-1:0]         rsp_data_out
`ifdef LOGIC_OP_ARB_CNT_EN
    ,
    output logic [15:0]              done_cnt_out
`endif
);

    state_e           state_q;
    logic [ID_W-1:0]  ptr_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gate_y;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  ptr_nxt;

    // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_in[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        ptr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        req_ready_out = '0;
        if (state_q == IDLE && found && !rst)
            req_ready_out[winner] = 1'b1;
    end

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (gate_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            op_q          <= OP_NOT_A;
            a_q           <= '0;
            b_q           <= '0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_data_out  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        op_q       <= op_e'(req_op_in[int'(winner)*OP_W +: OP_W]);
                        a_q        <= req_a_in[int'(winner)*WIDTH +: WIDTH];
                        b_q        <= req_b_in[int'(winner)*WIDTH +: WIDTH];
                        rsp_id_out <= winner;
                        ptr_q      <= ptr_nxt;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_out  <= gate_y;
                    rsp_valid_out <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_OP_ARB_CNT_EN
    // Saturating count of response handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_cnt_out <= '0;
        else if (state_q == RESP && rsp_ready_in && done_cnt_out != 16'hFFFF)
            done_cnt_out <= done_cnt_out + 16'd1;
    end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (NUM_REQ=4, WIDTH=8); covers LOGIC_OP_ARB_CNT_EN when defined.
module tb_logic_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [3*NUM_REQ-1:0]     req_op_in;
    logic [WIDTH*NUM_REQ-1:0] req_a_in;
    logic [WIDTH*NUM_REQ-1:0] req_b_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic                     rsp_valid_out;
    logic                     rsp_ready_in;
    logic [1:0]               rsp_id_out;
    logic [WIDTH-1:0]         rsp_data_out;
`ifdef LOGIC_OP_ARB_CNT_EN
    logic [15:0]              done_cnt_out;
`endif

    logic_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_in  (req_valid_in),
        .req_op_in     (req_op_in),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_ready_out (req_ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_id_out    (rsp_id_out),
        .rsp_data_out  (rsp_data_out)
`ifdef LOGIC_OP_ARB_CNT_EN
        ,
        .done_cnt_out  (done_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid_in[id]       = 1'b1;
        req_op_in[3*id +: 3]   = op;
        req_a_in[8*id +: 8]    = a;
        req_b_in[8*id +: 8]    = b;
    endtask

    // One isolated transaction with rsp_ready_in high; inputs scrambled after accept.
    task automatic run_txn(input string name, input int id, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        @(negedge clk);
        drive_req(id, op, a, b);
        #1 check({name, " ready"}, 32'(req_ready_out), 32'(4'b0001 << id));
        @(posedge clk);
        #1;
        req_valid_in = '0;
        req_a_in     = ~req_a_in;
        req_b_in     = ~req_b_in;
        req_op_in    = ~req_op_in;
        @(negedge clk);
        check({name, " exec valid"}, 32'(rsp_valid_out), 32'd0);
        check({name, " exec ready"}, 32'(req_ready_out), 32'd0);
        @(negedge clk);
        check({name, " rsp valid"}, 32'(rsp_valid_out), 32'd1);
        check({name, " rsp id"},    32'(rsp_id_out),    32'(id));
        check({name, " rsp data"},  32'(rsp_data_out),  32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         grant_id[6];
        int         grant_cyc[6];
        int         n_grant;
        int         last_grant;
        logic       saw_valid;

        vecs[0] = '{0, 3'd0, 8'hCA, 8'h53, 8'h35};
        vecs[1] = '{1, 3'd1, 8'hCA, 8'h53, 8'hAC};
        vecs[2] = '{2, 3'd2, 8'hCA, 8'h53, 8'h42};
        vecs[3] = '{3, 3'd3, 8'hCA, 8'h53, 8'hDB};
        vecs[4] = '{0, 3'd4, 8'hCA, 8'h53, 8'h24};
        vecs[5] = '{1, 3'd5, 8'hCA, 8'h53, 8'hBD};
        vecs[6] = '{2, 3'd6, 8'hCA, 8'h53, 8'h99};
        vecs[7] = '{3, 3'd7, 8'hCA, 8'h53, 8'h66};

        // Reset with random inputs
        rst          = 1'b1;
        req_valid_in = NUM_REQ'($urandom_range(1, 15));
        req_op_in    = 12'($urandom);
        req_a_in     = $urandom;
        req_b_in     = $urandom;
        rsp_ready_in = 1'($urandom);
        repeat (3) @(negedge clk);
        check("reset ready", 32'(req_ready_out), 32'd0);
        check("reset valid", 32'(rsp_valid_out), 32'd0);
        check("reset data",  32'(rsp_data_out),  32'd0);
        check("reset id",    32'(rsp_id_out),    32'd0);
`ifdef LOGIC_OP_ARB_CNT_EN
        check("reset cnt",   32'(done_cnt_out),  32'd0);
`endif
        req_valid_in = '0;
        rsp_ready_in = 1'b1;
        rst          = 1'b0;

        // Single request: req1 AND
        run_txn("single", 1, 3'd2, 8'hF0, 8'h3C, 8'h30);

        // Opcode coverage table
        for (int i = 0; i < 8; i++)
            run_txn($sformatf("op%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Fairness: ptr is 0 here, all four continuously valid
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++)
            drive_req(i, 3'd2, 8'(i + 1), 8'hFF);
        n_grant    = 0;
        last_grant = -1;
        for (int cyc = 0; cyc < 40 && n_grant < 6; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (rsp_valid_out)
                check("fair rsp id", 32'(rsp_id_out), 32'(last_grant));
            if (req_ready_out != '0) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ready_out[i]) grant_id[n_grant] = i;
                grant_cyc[n_grant] = cyc;
                last_grant = grant_id[n_grant];
                n_grant++;
            end
        end
        check("fair grant count", 32'(n_grant), 32'd6);
        for (int k = 0; k < n_grant; k++) begin
            check($sformatf("fair grant%0d id", k), 32'(grant_id[k]), 32'(k % 4));
            if (k > 0)
                check($sformatf("fair grant%0d spacing", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
        end
        @(posedge clk);
        #1 req_valid_in = '0;
        repeat (4) @(negedge clk);
        check("fair drained", 32'(rsp_valid_out), 32'd0);

        // Backpressure: ptr is 2; req0 also waiting
        @(negedge clk);
        rsp_ready_in = 1'b0;
        drive_req(2, 3'd6, 8'hCA, 8'h53);
        drive_req(0, 3'd2, 8'hFF, 8'hFF);
        #1 check("bp accept ready", 32'(req_ready_out), 32'b0100);
        @(posedge clk);
        #1 req_valid_in[2] = 1'b0;
        @(negedge clk);
        check("bp exec ready", 32'(req_ready_out), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d valid", c), 32'(rsp_valid_out), 32'd1);
            check($sformatf("bp hold%0d id", c),    32'(rsp_id_out),    32'd2);
            check($sformatf("bp hold%0d data", c),  32'(rsp_data_out),  32'h99);
            check($sformatf("bp hold%0d ready", c), 32'(req_ready_out), 32'd0);
        end
        rsp_ready_in = 1'b1;
        @(negedge clk);
        check("bp released valid", 32'(rsp_valid_out), 32'd0);
        check("bp released ready", 32'(req_ready_out), 32'b0001);
        #1 req_valid_in = '0;

        // Reset during EXEC: ptr is 3, so req1 wins via wrap
        @(negedge clk);
        drive_req(1, 3'd0, 8'h0F, 8'h00);
        #1 check("rst accept ready", 32'(req_ready_out), 32'b0010);
        @(posedge clk);
        #1 req_valid_in = '0;
        @(negedge clk);
`ifdef LOGIC_OP_ARB_CNT_EN
        check("cnt before rst", 32'(done_cnt_out), 32'd16);
`endif
        #1 rst = 1'b1;
        #1;
        check("rst mid valid", 32'(rsp_valid_out), 32'd0);
        check("rst mid data",  32'(rsp_data_out),  32'd0);
        check("rst mid id",    32'(rsp_id_out),    32'd0);
`ifdef LOGIC_OP_ARB_CNT_EN
        check("rst mid cnt",   32'(done_cnt_out),  32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_out) saw_valid = 1'b1;
        end
        check("rst no response", 32'(saw_valid), 32'd0);
        req_valid_in = 4'b1111;
        #1 check("rst ptr zero", 32'(req_ready_out), 32'b0001);
        req_valid_in = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
